mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-1 single-bit mux between four requesters.
- Grants one requester at a time and drives the mux select lines s0/s1 with the matching index.
- Caps how long one requester can hold the mux, so a stuck requester cannot starve the others.
- Sits directly in front of the mux select pins; requesters hold their data on the matching mux input while granted.

Parameters:
- MAX_HOLD, 8: maximum consecutive granted cycles per owner while others wait. Legal range ≥2.
- CNT_W, 3: hold-counter width. Must satisfy 2^CNT_W ≥ MAX_HOLD.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous active-high reset.
- req, input, 4: request vector; req[i] requests mux input i.
- gnt, output, 4: one-hot registered grant, or all-zero.
- sel_s0, output, 1: mux select MSB; {sel_s0,sel_s1} is the granted index.
- sel_s1, output, 1: mux select LSB.
- busy, output, 1: high while any grant is active (equals |gnt).

Behaviour:
- Reset (async, immediate): state=IDLE, gnt=0, busy=0, sel_s0=0, sel_s1=0, hold_cnt=0, last=3. With last=3, index 0 has first priority.
- Index mapping: index = 2*sel_s0 + sel_s1, matching mux case order {s0,s1}: 00→i0, 01→i1, 10→i2, 11→i3.
- Priority search: starts at (last+1) mod 4 and wraps ascending. The first asserted candidate wins.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise: at the next edge, gnt=onehot(winner), sel=winner, last=winner, hold_cnt=0, go to GRANT.
  - Latency from req assertion to gnt is 1 cycle.
- GRANT (owner = last). Evaluated each edge, in priority order:
  1. req[owner]==0 (release): re-arbitrate over req with the owner excluded. If a winner exists, hand over at this edge with no idle gap and hold_cnt=0. Otherwise gnt=0 and go to IDLE.
  2. hold_cnt==MAX_HOLD-1 and another req is pending (timeout): hand over to the round-robin winner among the others at this edge, hold_cnt=0. The preempted owner keeps requesting and is served again in rotation.
  3. hold_cnt==MAX_HOLD-1 and no other req: owner keeps the grant and hold_cnt wraps to 0.
  4. Otherwise: hold the grant and increment hold_cnt.
- sel_s0/sel_s1 are only updated at a grant edge. They hold the last granted index through IDLE so the mux output stays stable.
- gnt is never multi-hot. A handover changes gnt in a single edge, with no overlap cycle.
- Requests arriving or changing mid-grant do not affect the owner until rule 1 or 2 applies.
- Reset asserted mid-grant clears gnt combinationally-asynchronously. After reset the priority pointer restarts at index 0.
- All outputs are registered; there is no combinational path from req to gnt.

Optional Feature:
- Macro: MUX4_ARB_GRANT_CNT_EN.
- Defined:
  - Adds output grant_cnt (16 bits).
  - Increments by 1 on every edge where a new grant is issued: IDLE→GRANT or a handover. A hold wrap under rule 3 is not counted.
  - Saturates at 16'hFFFF. Reset value 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset then single request: assert rst; expect gnt=0000, sel=00, busy=0. Release rst, drive req=0100 → next edge gnt=0100, sel_s0=1, sel_s1=0, busy=1.
- Round-robin fairness: req=1111 held, MAX_HOLD=8 → grant order 0,1,2,3,0. Each owner holds exactly 8 cycles with no gap cycles between owners.
- Release handover: owner 1 granted with req=0110 pending; drop req[1] → at the same edge gnt=0100. Drop req[2] with req=0 → gnt=0000, busy=0, sel stays 10.
- Timeout with no contention: req=0001 held for 20 cycles → gnt stays 0001 throughout, and hold_cnt wraps every 8 cycles.
- Wrap-around priority: last=3 (owner 3 released), req=1001 → winner 0. Next, with last=0 and req=1001 → winner 3.
- Async reset mid-grant: pulse rst between edges during gnt=0010 → gnt=0000 immediately. After release, req=1111 → gnt=0001. With MUX4_ARB_GRANT_CNT_EN defined, grant_cnt reads 1.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// rtl/mux4_rr_arbiter_if.sv - request/grant/select bundle between requesters and the 4-input mux arbiter
// Optional member grant_cnt exists only when MUX4_ARB_GRANT_CNT_EN is defined.
interface mux4_rr_arbiter_if;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        sel_s0;
  logic        sel_s1;
  logic        busy;
`ifdef MUX4_ARB_GRANT_CNT_EN
  logic [15:0] grant_cnt;

  modport master (output req, input gnt, input sel_s0, input sel_s1, input busy, input grant_cnt);
  modport slave  (input req, output gnt, output sel_s0, output sel_s1, output busy, output grant_cnt);
`else
  modport master (output req, input gnt, input sel_s0, input sel_s1, input busy);
  modport slave  (input req, output gnt, output sel_s0, output sel_s1, output busy);
`endif
endinterface

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter with hold cap driving the select pins of a shared 4:1 mux
// Define MUX4_ARB_GRANT_CNT_EN to add the saturating 16-bit grant_cnt output.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  mux4_rr_arbiter_if.slave   bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  generate
    if (MAX_HOLD < 2 || (1 << CNT_W) < MAX_HOLD) begin : g_param_check
      $error("mux4_rr_arbiter: MAX_HOLD must be >= 2 and fit in CNT_W bits");
    end
  endgenerate

  logic [0:0]       r_state;
  logic [1:0]       r_last;
  logic [1:0]       r_sel;
  logic [3:0]       r_gnt;
  logic [CNT_W-1:0] r_hold;

  logic [0:0]       w_nxt_state;
  logic [CNT_W-1:0] w_nxt_hold;
  logic             w_issue;
  logic [1:0]       w_issue_idx;
  logic             w_drop;
  logic [3:0]       w_owner_oh;
  logic [3:0]       w_others;
  logic [2:0]       w_pick_all;
  logic [2:0]       w_pick_oth;
  logic             w_at_limit;

  // Returns {found, index}; scan begins just after start_after and wraps ascending.
  function automatic logic [2:0] f_pick(input logic [3:0] cand, input logic [1:0] start_after);
    logic       found;
    logic [1:0] idx;
    logic [1:0] i;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      i = start_after + 2'(k);
      if (!found && cand[i]) begin
        found = 1'b1;
        idx   = i;
      end
    end
    return {found, idx};
  endfunction

  assign w_owner_oh = 4'b0001 << r_last;
  assign w_others   = bus.req & ~w_owner_oh;
  assign w_pick_all = f_pick(bus.req, r_last);
  assign w_pick_oth = f_pick(w_others, r_last);
  assign w_at_limit = (r_hold == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_hold  = r_hold;
    w_issue     = 1'b0;
    w_issue_idx = r_last;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_all[2]) begin
          w_issue     = 1'b1;
          w_issue_idx = w_pick_all[1:0];
        end
      end
      default: begin
        if (!bus.req[r_last]) begin
          if (w_pick_oth[2]) begin
            w_issue     = 1'b1;
            w_issue_idx = w_pick_oth[1:0];
          end else begin
            w_drop = 1'b1;
          end
        end else if (w_at_limit) begin
          // Preempt only if someone else is waiting; otherwise the owner keeps going.
          if (w_pick_oth[2]) begin
            w_issue     = 1'b1;
            w_issue_idx = w_pick_oth[1:0];
          end else begin
            w_nxt_hold = '0;
          end
        end else begin
          w_nxt_hold = r_hold + CNT_W'(1);
        end
      end
    endcase
    if (w_issue) begin
      w_nxt_state = ST_GRANT;
      w_nxt_hold  = '0;
    end else if (w_drop) begin
      w_nxt_state = ST_IDLE;
      w_nxt_hold  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= 2'd3;
      r_sel   <= 2'd0;
      r_gnt   <= 4'd0;
      r_hold  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_hold  <= w_nxt_hold;
      if (w_issue) begin
        r_gnt  <= 4'b0001 << w_issue_idx;
        r_sel  <= w_issue_idx;
        r_last <= w_issue_idx;
      end else if (w_drop) begin
        r_gnt  <= 4'd0;
      end
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.sel_s0 = r_sel[1];
  assign bus.sel_s1 = r_sel[0];
  assign bus.busy   = |r_gnt;

`ifdef MUX4_ARB_GRANT_CNT_EN
  logic [15:0] r_grant_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_cnt <= 16'd0;
    end else if (w_issue && r_grant_cnt != 16'hFFFF) begin
      r_grant_cnt <= r_grant_cnt + 16'd1;
    end
  end

  assign bus.grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - scoreboard bench for mux4_rr_arbiter with directed and random request traffic
// Reference model tracks owner/tenure as integers; a monitor compares every post-edge output.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mux4_rr_arbiter_if bus();

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int m_owner, m_last, m_sel, m_ten, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] c, input int after);
    for (int k = 1; k <= 4; k++) begin
      if (c[(after + k) % 4]) return (after + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_sel   = 0;
    m_ten   = 0;
    m_cnt   = 0;
  endtask

  task automatic model_take(input int w);
    m_owner = w;
    m_last  = w;
    m_sel   = w;
    m_ten   = 1;
    if (m_cnt < 65535) m_cnt++;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] others;
    int w;
    if (m_owner < 0) begin
      w = rr_pick(r, m_last);
      if (w >= 0) model_take(w);
    end else begin
      others = r & ~(4'b0001 << m_owner);
      w = rr_pick(others, m_owner);
      if (!r[m_owner]) begin
        if (w >= 0) model_take(w);
        else m_owner = -1;
      end else if (m_ten == MAX_HOLD) begin
        if (w >= 0) model_take(w);
        else m_ten = 1;
      end else begin
        m_ten++;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      model_reset();
    end else begin
      model_step(bus.req);
      e.gnt  = (m_owner < 0) ? 4'd0 : (4'b0001 << m_owner);
      e.sel  = 2'(m_sel);
      e.busy = (m_owner >= 0);
      e.cnt  = 16'(m_cnt);
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_gnt", 32'(bus.gnt), 32'(e.gnt));
          chk("sb_sel", 32'({bus.sel_s0, bus.sel_s1}), 32'(e.sel));
          chk("sb_busy", 32'(bus.busy), 32'(e.busy));
`ifdef MUX4_ARB_GRANT_CNT_EN
          chk("sb_grant_cnt", 32'(bus.grant_cnt), 32'(e.cnt));
`endif
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 4'd0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin : stim
    bus.req = 4'd0;
    model_reset();
    cyc();
    // Reset state
    do_reset();
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_sel", 32'({bus.sel_s0, bus.sel_s1}), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);

    // Single request, one-cycle latency
    bus.req = 4'b0100;
    cyc();
    chk("single_gnt", 32'(bus.gnt), 32'h4);
    chk("single_sel", 32'({bus.sel_s0, bus.sel_s1}), 32'h2);
    chk("single_busy", 32'(bus.busy), 32'h1);
    bus.req = 4'd0;
    cyc();

    // Round-robin fairness with all requesting
    do_reset();
    bus.req = 4'b1111;
    for (int n = 1; n <= 33; n++) begin
      cyc();
      chk("rr_order", 32'(bus.gnt), 32'(4'b0001 << (((n - 1) / MAX_HOLD) % 4)));
    end

    // Release handover then release to idle
    do_reset();
    bus.req = 4'b0010;
    cyc();
    bus.req = 4'b0110;
    cyc();
    chk("rel_owner1", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0100;
    cyc();
    chk("rel_handover", 32'(bus.gnt), 32'h4);
    bus.req = 4'b0000;
    cyc();
    chk("rel_idle_gnt", 32'(bus.gnt), 32'h0);
    chk("rel_idle_busy", 32'(bus.busy), 32'h0);
    chk("rel_idle_sel", 32'({bus.sel_s0, bus.sel_s1}), 32'h2);

    // Uncontended owner survives hold wraps
    bus.req = 4'b0001;
    for (int n = 0; n < 20; n++) begin
      cyc();
      chk("solo_hold", 32'(bus.gnt), 32'h1);
    end

    // Wrap-around priority
    do_reset();
    bus.req = 4'b1000;
    cyc();
    chk("wrap_own3", 32'(bus.gnt), 32'h8);
    bus.req = 4'b0000;
    cyc();
    bus.req = 4'b1001;
    cyc();
    chk("wrap_win0", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0000;
    cyc();
    bus.req = 4'b1001;
    cyc();
    chk("wrap_win3", 32'(bus.gnt), 32'h8);

    // Async reset pulse between edges
    do_reset();
    bus.req = 4'b0010;
    cyc();
    chk("ar_pre", 32'(bus.gnt), 32'h2);
    #1 rst = 1'b1;
    #1 chk("ar_async_gnt", 32'(bus.gnt), 32'h0);
    chk("ar_async_busy", 32'(bus.busy), 32'h0);
    #1 rst = 1'b0;
    bus.req = 4'b1111;
    cyc();
    chk("ar_after", 32'(bus.gnt), 32'h1);
`ifdef MUX4_ARB_GRANT_CNT_EN
    chk("ar_grant_cnt", 32'(bus.grant_cnt), 32'h1);
`endif

    // Randomized traffic checked by the scoreboard
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
      cyc();
    end

    bus.req = 4'd0;
    cyc();
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
